// File: rtl/touch_led_mode_ctrl.sv
// Touch-key LED mode controller: sync + press edge detect, OFF->ON->SLOW->FAST mode stepping, blink.
// Optional long-press return to OFF when TOUCH_LONG_PRESS_EN is defined.
module touch_led_mode_ctrl #(
    parameter int unsigned SLOW_HALF  = 25_000_000,
    parameter int unsigned FAST_HALF  = 5_000_000,
    parameter int unsigned LONG_PRESS = 100_000_000,
    parameter int unsigned CNT_W      = 27
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       touch_key,
    output logic       led,
    output logic [1:0] mode,
    output logic       press_pulse
);

    typedef enum logic [1:0] {M_OFF = 2'd0, M_ON = 2'd1, M_SLOW = 2'd2, M_FAST = 2'd3} mode_e;

    localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(SLOW_HALF - 1);
    localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_HALF - 1);

    generate
        if (LONG_PRESS < 2 || SLOW_HALF < 1 || FAST_HALF < 1) begin : g_bad_cfg
            $error("touch_led_mode_ctrl: invalid count parameters");
        end
    endgenerate

    logic             sync1_q, key_s_q, key_d_q;
    logic             sync1_d, key_s_d, key_d_d;
    mode_e            mode_q, mode_d;
    logic             led_q, led_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             blink_ph_q, blink_ph_d;
    logic [CNT_W-1:0] half_last;
    logic             long_fire;

`ifdef TOUCH_LONG_PRESS_EN
    localparam logic [CNT_W-1:0] LP_MAX  = CNT_W'(LONG_PRESS);
    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(LONG_PRESS - 1);
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        long_fire  = 1'b0;
        if (key_s_q) begin
            hold_cnt_d = '0;
        end else if (hold_cnt_q < LP_MAX) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
            long_fire  = (hold_cnt_q == LP_LAST);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) hold_cnt_q <= '0;
        else            hold_cnt_q <= hold_cnt_d;
    end
`else
    assign long_fire = 1'b0;
`endif

    always_comb begin
        sync1_d     = touch_key;
        key_s_d     = sync1_q;
        key_d_d     = key_s_q;
        press_d     = key_d_q & ~key_s_q;
        mode_d      = mode_q;
        blink_cnt_d = blink_cnt_q;
        blink_ph_d  = blink_ph_q;
        led_d       = 1'b0;

        if (press_d) begin
            unique case (mode_q)
                M_OFF:   mode_d = M_ON;
                M_ON:    mode_d = M_SLOW;
                M_SLOW:  mode_d = M_FAST;
                default: mode_d = M_OFF;
            endcase
        end
        // Long press overrides any same-cycle advance and always lands in OFF.
        if (long_fire) mode_d = M_OFF;

        half_last = (mode_q == M_FAST) ? FAST_LAST : SLOW_LAST;
        if (mode_d != mode_q) begin
            blink_cnt_d = '0;
            blink_ph_d  = 1'b1;
        end else if (mode_q == M_SLOW || mode_q == M_FAST) begin
            if (blink_cnt_q == half_last) begin
                blink_cnt_d = '0;
                blink_ph_d  = ~blink_ph_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end else begin
            blink_cnt_d = '0;
        end

        unique case (mode_d)
            M_OFF:   led_d = 1'b0;
            M_ON:    led_d = 1'b1;
            default: led_d = blink_ph_d;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q     <= 1'b1;
            key_s_q     <= 1'b1;
            key_d_q     <= 1'b1;
            mode_q      <= M_OFF;
            led_q       <= 1'b0;
            press_q     <= 1'b0;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b1;
        end else begin
            sync1_q     <= sync1_d;
            key_s_q     <= key_s_d;
            key_d_q     <= key_d_d;
            mode_q      <= mode_d;
            led_q       <= led_d;
            press_q     <= press_d;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
        end
    end

    assign led         = led_q;
    assign mode        = mode_q;
    assign press_pulse = press_q;

endmodule

// File: tb/tb_touch_led_mode_ctrl.sv
// Self-checking bench for touch_led_mode_ctrl; expected modes go through a scoreboard queue.
module tb_touch_led_mode_ctrl;

    localparam int SH = 4;
    localparam int FH = 2;
    localparam int LP = 20;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       touch_key = 1'b1;
    logic       led;
    logic [1:0] mode;
    logic       press_pulse;

    int errors = 0;
    int checks = 0;
    int pulse_cnt = 0;
    int exp_mode = 0;
    int exp_q[$];

    touch_led_mode_ctrl #(
        .SLOW_HALF(SH), .FAST_HALF(FH), .LONG_PRESS(LP), .CNT_W(27)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .touch_key(touch_key),
        .led(led), .mode(mode), .press_pulse(press_pulse)
    );

    always #10 sys_clk = ~sys_clk;

    always @(negedge sys_clk) if (press_pulse === 1'b1) pulse_cnt++;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge sys_clk);
            #1;
        end
    endtask

    // Drive one press of `low` cycles followed by `high` idle cycles, checking every cycle.
    task automatic do_press(input int low, input int high);
        int em, mq, half;
        logic el;
        touch_key = 1'b0;
        exp_mode = (exp_mode + 1) % 4;
        exp_q.push_back(exp_mode);
        tick(3);
        for (int k = 0; k < low + high - 3; k++) begin
            em = exp_mode;
`ifdef TOUCH_LONG_PRESS_EN
            if (low >= LP && k >= LP - 1) em = 0;
`endif
            half = (em == 3) ? FH : SH;
            el = (em == 0) ? 1'b0 : (em == 1) ? 1'b1 : (((k / half) % 2) == 0);
            checks++;
            if (k == 0) begin
                if (press_pulse !== 1'b1) begin
                    errors++;
                    $display("FAIL press_pulse_hi k=%0d got %b want 1", k, press_pulse);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_empty got 0 entries want 1");
                end else begin
                    mq = exp_q.pop_front();
                    if (mode !== 2'(mq)) begin
                        errors++;
                        $display("FAIL sb_mode got %0d want %0d", mode, mq);
                    end
                end
            end else if (press_pulse !== 1'b0) begin
                errors++;
                $display("FAIL press_pulse_lo k=%0d got %b want 0", k, press_pulse);
            end
            checks++;
            if (mode !== 2'(em)) begin
                errors++;
                $display("FAIL mode k=%0d got %0d want %0d", k, mode, em);
            end
            checks++;
            if (led !== el) begin
                errors++;
                $display("FAIL led mode=%0d k=%0d got %b want %b", em, k, led, el);
            end
            if (k == low - 3) touch_key = 1'b1;
            tick();
        end
`ifdef TOUCH_LONG_PRESS_EN
        if (low >= LP) exp_mode = 0;
`endif
    endtask

    task automatic short_reset();
        sys_rst_n = 1'b0;
        touch_key = 1'b1;
        tick(3);
        sys_rst_n = 1'b1;
        exp_mode = 0;
        exp_q.delete();
        tick(3);
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        touch_key = 1'b1;
        tick(50);
        sys_rst_n = 1'b1;
        exp_mode = 0;
        for (int i = 0; i < 20; i++) begin
            checks++;
            if ({led, mode, press_pulse} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got led=%b mode=%0d pulse=%b want 0/0/0",
                         i, led, mode, press_pulse);
            end
            tick();
        end
    endtask

    task automatic test_single_press();
        do_press(10, 10);
    endtask

    task automatic test_cycle_modes();
        short_reset();
        for (int i = 0; i < 4; i++) do_press(10, 10);
        checks++;
        if (led !== 1'b0 || mode !== 2'd0) begin
            errors++;
            $display("FAIL cycle_end got led=%b mode=%0d want 0/0", led, mode);
        end
    endtask

    task automatic test_long_press();
        int p0;
        p0 = pulse_cnt;
        do_press(40, 10);
        checks++;
        if (pulse_cnt - p0 != 1) begin
            errors++;
            $display("FAIL long_press_pulses got %0d want 1", pulse_cnt - p0);
        end
    endtask

    task automatic test_reset_mid_blink();
        short_reset();
        do_press(10, 10);
        do_press(10, 10);
        checks++;
        if (mode !== 2'd2 || led !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset got mode=%0d led=%b want 2/1", mode, led);
        end
        sys_rst_n = 1'b0;
        #1;
        checks++;
        if (led !== 1'b0 || mode !== 2'd0 || press_pulse !== 1'b0) begin
            errors++;
            $display("FAIL async_clear got led=%b mode=%0d want 0/0", led, mode);
        end
        tick();
        sys_rst_n = 1'b1;
        exp_mode = 0;
        exp_q.delete();
        tick(2);
        do_press(10, 10);
        do_press(10, 10);
    endtask

    task automatic test_key_low_reset();
        int p0;
        sys_rst_n = 1'b0;
        touch_key = 1'b0;
        tick(5);
        sys_rst_n = 1'b1;
        exp_mode = 1;
        exp_q.delete();
        exp_q.push_back(exp_mode);
        p0 = pulse_cnt;
        tick(3);
        checks++;
        if (press_pulse !== 1'b1) begin
            errors++;
            $display("FAIL held_pulse got %b want 1", press_pulse);
        end
        checks++;
        if (mode !== 2'(exp_q.pop_front())) begin
            errors++;
            $display("FAIL held_mode got %0d want 1", mode);
        end
        tick();
        checks++;
        if (press_pulse !== 1'b0) begin
            errors++;
            $display("FAIL held_pulse_drop got %b want 0", press_pulse);
        end
        tick(4);
        touch_key = 1'b1;
        tick(6);
        checks++;
        if (pulse_cnt - p0 != 1 || mode !== 2'd1) begin
            errors++;
            $display("FAIL held_total got pulses=%0d mode=%0d want 1/1", pulse_cnt - p0, mode);
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_cycle_modes();
        test_long_press();
        test_reset_mid_blink();
        test_key_low_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/touch_led_mode_ctrl.md
# touch_led_mode_ctrl

Touch-key LED mode controller. Synchronises the raw `touch_key` input, detects press edges and steps a four-state LED mode machine: OFF, ON, slow blink, fast blink. It sits between the touch sensor pin and the board LED and replaces the plain press-to-toggle behaviour with a sequenced mode scheduler, with an optional long-press return to OFF.

## Interface
- `SLOW_HALF`, default 25_000_000: half-period of slow blink, in clock cycles (0.5 s at 50 MHz).
- `FAST_HALF`, default 5_000_000: half-period of fast blink, in clock cycles.
- `LONG_PRESS`, default 100_000_000: hold time that forces OFF, in clock cycles (2 s); must be ≥ 2.
- `CNT_W`, default 27: width of the blink and hold counters; every count parameter must be < 2^CNT_W.
- `sys_clk`  in  1  system clock, 50 MHz.
- `sys_rst_n`  in  1  reset, asynchronous, active-low.
- `touch_key`  in  1  raw touch input, asynchronous to `sys_clk`; idle 1, pressed 0.
- `led`  out  1  LED drive, 1 = lit.
- `mode`  out  2  current mode: 0 = OFF, 1 = ON, 2 = SLOW, 3 = FAST.
- `press_pulse`  out  1  one-cycle strobe on each detected press.

## Operation
- **Synchroniser:** two flops `sync1` → `key_s`, plus a delay flop `key_d`. All three reset to 1 (idle).
- **Press detection:** press = `key_d & ~key_s`, i.e. a falling edge of the synchronised key. Release is not an event; only presses step the machine.
- **Mode FSM:** each press advances OFF→ON→SLOW→FAST→OFF, wrapping from FAST back to OFF.
- **Blink counter:**
  - `blink_cnt` is cleared and `blink_ph` set to 1 on every mode change.
  - In SLOW or FAST, `blink_cnt` counts 0..HALF-1. At HALF-1 it wraps to 0 and `blink_ph` toggles. HALF is the `SLOW_HALF` or `FAST_HALF` of the current mode.
  - In OFF or ON, `blink_cnt` is held at 0.
- **LED mapping:** OFF gives `led`=0; ON gives `led`=1; SLOW and FAST give `led`=`blink_ph`. `led` is registered, as is `mode`.
- **Long press:** handled by the `hold_cnt` counter (see Configuration).
- **Key held low through reset release:** the synchronised falling edge after reset counts as a press.

## Timing
- **Reset values:** `led`=0, `mode`=0, `press_pulse`=0; all counters 0; `sync1`/`key_s`/`key_d`=1.
- **Press latency:** `touch_key` falls before rising edge E0.
  - `key_s`=0 after E1.
  - `press_pulse`=1, `mode` updated and `led` updated, all after E2.
  - `press_pulse` drops after E3.
- **Blink waveform:** on entering SLOW, `led`=1 for SLOW_HALF cycles, then 0 for SLOW_HALF cycles, repeating. Period is 2·HALF and the first phase is full length.
- **Glitch rejection:** a key low pulse shorter than one clock may be missed. Any low level captured by `key_s` produces exactly one press.
- **Reset mid-operation:** asynchronous clear to the reset values above, immediately, regardless of the current mode or counter state.

## Configuration
- **`TOUCH_LONG_PRESS_EN` defined:**
  - `hold_cnt` increments every cycle while `key_s`=0 and saturates at `LONG_PRESS`. It clears when `key_s`=1.
  - On the edge where `hold_cnt` goes LONG_PRESS-1 → LONG_PRESS, `mode` is forced to OFF and `led` to 0.
  - This fires once per hold. No `press_pulse` is generated for it.
  - The short-press advance at the start of the hold still occurs first.
- **Undefined:** no `hold_cnt`; holding the key has no effect beyond the initial press.

## Test plan
All scenarios use parameters SLOW_HALF=4, FAST_HALF=2, LONG_PRESS=20, with a 20 ns clock.
- **Reset with key idle:** assert `sys_rst_n`=0 for 50 cycles with `touch_key`=1, then release → `led`=0, `mode`=0, `press_pulse`=0, and no press for 20 cycles.
- **Single press:** `touch_key` low for 10 cycles → `press_pulse` high exactly one cycle, 3 edges after the fall; `mode`=1, `led`=1 on the same edge.
- **Cycle through modes:** four separate presses, 10 cycles low and 10 high each → `mode` sequence 1,2,3,0.
  - In SLOW, `led` shows 4 high / 4 low.
  - In FAST, `led` shows 2 high / 2 low.
  - After the fourth press, `led`=0.
- **Long press:**
  - With `TOUCH_LONG_PRESS_EN`: from OFF, hold low for 40 cycles → `mode`=1 at 3 edges; `mode`=0 and `led`=0, 20 cycles after `key_s` fell; one `press_pulse` total.
  - Without the macro: `mode` stays 1.
- **Reset mid-blink:** in SLOW, pulse `sys_rst_n` low for 1 cycle → `led`, `mode` and counters clear immediately; the next press gives `mode`=1.
- **Key held low through reset release:** `touch_key`=0 during reset, then release → one `press_pulse` 3 edges after release, `mode`=1.
